// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin mux arbiter.
//   idx_width     : index width for N requesters (at least 1 bit).
//   onehot_to_idx : encodes a one-hot vector of up to MAX_N bits into an index.
package arb_pkg;

  localparam int MAX_N     = 64;
  localparam int IDX_MAX_W = $clog2(MAX_N);

  // Width of a requester index; never zero, even for degenerate N.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the set bit in a one-hot vector; returns 0 when no bit is set.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin selector.
// Searches req upward from ptr, wrapping modulo N, and grants the first set bit.
// Ports:
//   req        in  [N]   request vector
//   ptr        in  [IDW] highest-priority requester
//   gnt_onehot out [N]   one-hot grant (all-zero when nothing is requested)
//   gnt_idx    out [IDW] index of the granted requester (0 when none)
//   gnt_any    out       at least one request is present
module round_robin_select
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [MAX_N-1:0] oh_ext;

  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    int  pos;
    logic found;
    gnt_onehot = '0;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr never exceeds N-1, so one conditional subtract is a full modulo.
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        gnt_onehot[pos] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  always_comb begin
    oh_ext         = '0;
    oh_ext[N-1:0]  = gnt_onehot;
  end

  assign gnt_idx = IDW'(onehot_to_idx(oh_ext));
  assign gnt_any = |req;

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter sharing one registered W-bit output among N
// valid/ready requesters.  Pass-through ready: a new item is accepted in
// the same edge that the held item drains, sustaining 1 item per cycle.
// Ports:
//   clk       in        rising-edge clock
//   rst       in        synchronous reset, active-high
//   in_valid  in  [N]   requester i offers data
//   in_ready  out [N]   requester i's data is accepted this cycle (one-hot)
//   in_data   in  [N*W] requester i at bits [i*W +: W]
//   out_valid out       output register holds an item
//   out_ready in        downstream accepts the item
//   out_data  out [W]   registered data
//   out_id    out [IDW] registered index of the supplying requester
module round_robin_mux_arbiter
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IDW-1:0] out_id
);

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic [IDW-1:0] out_id_q,    out_id_d;
  logic [IDW-1:0] ptr_q,       ptr_d;

  logic [N-1:0]   gnt_onehot;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           can_accept;
  logic           accept;
  logic [W-1:0]   mux_data;

  round_robin_select #(
    .N   (N),
    .IDW (IDW)
  ) u_select (
    .req        (in_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // The output slot is free when empty or when its item leaves this edge.
  assign can_accept = !out_valid_q || out_ready;
  // Nothing is accepted during reset, so no requester sees a phantom handshake.
  assign accept     = gnt_any && can_accept && !rst;
  assign in_ready   = gnt_onehot & {N{accept}};

  assign mux_data = in_data[gnt_idx*W +: W];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      // Drain only: data and id keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Directed, table-driven bench for round_robin_mux_arbiter (N=4, W=8).
module tb_round_robin_mux_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;

  int total = 0;
  int bad   = 0;

  round_robin_mux_arbiter #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   iv;
    logic           ordy;
    logic [N-1:0]   exp_rdy;
    logic           exp_ov;
    logic [IDW-1:0] exp_id;
    logic [W-1:0]   exp_d;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [IDW-1:0] id,
                           input logic [W-1:0] d);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_id"},    32'(out_id),    32'(id));
    check({tag, ".out_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    // Fairness: full rotation 0..3 then 0 again.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    // Sparse / wrap: grant 2 (ptr->3), lone request 1 wraps (ptr->2),
    // then 1001 grants 3 before 0.
    vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    vecs[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    // Backpressure for 3 cycles: nothing accepted, output frozen (ptr=1).
    vecs[9]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    vecs[10] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    vecs[11] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    // Release: drain and accept of requester 2 on the same edge (ptr->3).
    vecs[12] = '{4'b0101, 1'b1, 4'b0000 | 4'b0100, 1'b1, 2'd2, 8'h33};
    // Drain only, then idle with out_ready low; id/data hold, ptr stays 3.
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h33};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h33};
    // Empty register accepts even with out_ready low; ptr=3 picks requester 3.
    vecs[15] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h44};
    // Set up out_valid=1 with ptr=2 for the mid-operation reset.
    vecs[16] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};

    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset held for two edges with every requester valid.
    #1;
    check("rst0.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("rst1.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("rst2.in_ready", 32'(in_ready), 32'h0);
    check_out("rst2", 1'b0, 2'd0, 8'h00);

    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'b0001);

    for (int i = 0; i < NV; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_id, vecs[i].exp_d);
    end

    // Mid-operation reset: held item discarded, no handshake in reset cycle.
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    check("mid_rst.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check_out("mid_rst", 1'b0, 2'd0, 8'h00);

    // ptr back at 0: requester 0 wins first.
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("after_rst.in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    check_out("after_rst", 1'b1, 2'd0, 8'h11);
    #1;
    check("after_rst2.in_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    check_out("after_rst2", 1'b1, 2'd1, 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
